off_chip_rx_packer: RTL and testbench

- Downstream stage of the off-chip byte deinterleaver.
- Consumes its 8-bit valid/ready byte stream and packs 4 consecutive bytes little-endian into a 32-bit word.
- Buffers completed words in a small FIFO and presents them on a 32-bit valid/ready port with per-byte keep mask to the on-chip consumer.
- A flush request closes a partial word (zero padded, keep mask marks real bytes).

---
 rtl/off_chip_pkg.sv | 17 +
 rtl/off_chip_rx_fifo.sv | 52 +++++
 rtl/off_chip_rx_packer.sv | 132 +++++++++++++
 tb/tb_off_chip_rx_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/off_chip_pkg.sv
// Shared widths, receive-state encoding and keep-mask table for the off-chip
// receive packer.
package off_chip_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    ST_FILL       = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } rx_state_e;

  // Entry n marks the low n bytes of a word as real data.
  localparam logic [LANES:0][LANES-1:0] KEEP_TABLE = {4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

endpackage

// File: rtl/off_chip_rx_fifo.sv
// Synchronous word+keep FIFO; the head is read straight from storage and the
// last popped entry is held so the output stays stable while empty.
module off_chip_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  // The extra top pointer bit tells a full FIFO from an empty one.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign valid_o = !empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/off_chip_rx_packer.sv
// Packs the deinterleaved byte stream into little-endian 32-bit words with a
// keep mask; statistics counters exist only when OFF_CHIP_RX_STATS_EN is defined.
module off_chip_rx_packer
  import off_chip_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [BYTE_W-1:0]    in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [WORD_W-1:0]    out_data_o,
  output logic [LANES-1:0]     out_keep_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] byte_cnt_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  rx_state_e         state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] asm_q, asm_d, asm_byte;
  logic              started_q;
  logic              xfer, push, pop;
  logic [2:0]        fill_n;
  logic [WORD_W-1:0] push_data;
  logic [LANES-1:0]  push_keep;
  logic              fifo_full, fifo_empty;

  // in_ready depends only on registers, so upstream sees no combinational loop.
  assign in_ready_o = started_q && (state_q == ST_FILL) && !(fifo_full && (lane_q == 2'd3));
  assign xfer       = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;

  always_comb begin
    asm_byte = asm_q;
    if (xfer) asm_byte[{lane_q, 3'b000} +: BYTE_W] = in_data_i;
    fill_n    = {1'b0, lane_q} + {2'b00, xfer};
    state_d   = state_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    push      = 1'b0;
    push_data = asm_byte;
    push_keep = KEEP_TABLE[fill_n];
    case (state_q)
      ST_FILL: begin
        if (xfer && (lane_q == 2'd3)) begin
          push   = 1'b1;
          lane_d = 2'd0;
          asm_d  = '0;
        end else if (flush_i && (fill_n != 3'd0)) begin
          if (!fifo_full) begin
            push   = 1'b1;
            lane_d = 2'd0;
            asm_d  = '0;
          end else begin
            state_d = ST_FLUSH_WAIT;
            asm_d   = asm_byte;
            lane_d  = fill_n[1:0];
          end
        end else if (xfer) begin
          asm_d  = asm_byte;
          lane_d = lane_q + 2'd1;
        end
      end
      ST_FLUSH_WAIT: begin
        push_data = asm_q;
        push_keep = KEEP_TABLE[{1'b0, lane_q}];
        if (!fifo_full) begin
          push    = 1'b1;
          lane_d  = 2'd0;
          asm_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_FILL;
      lane_q    <= 2'd0;
      asm_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      started_q <= 1'b1;
    end
  end

  off_chip_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W + LANES)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i ({push_keep, push_data}),
    .pop_i  (pop),
    .data_o ({out_keep_o, out_data_o}),
    .valid_o(out_valid_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef OFF_CHIP_RX_STATS_EN
  logic [CNT_WIDTH-1:0] byte_cnt_q, word_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      if (xfer) byte_cnt_q <= byte_cnt_q + CNT_WIDTH'(1);
      if (push) word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign byte_cnt_o = byte_cnt_q;
  assign word_cnt_o = word_cnt_q;
`else
  assign byte_cnt_o = '0;
  assign word_cnt_o = '0;
`endif

endmodule

// File: tb/tb_off_chip_rx_packer.sv
// Scoreboard bench for off_chip_rx_packer; expected counters follow OFF_CHIP_RX_STATS_EN.
module tb_off_chip_rx_packer;

`ifdef OFF_CHIP_RX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        flush = 1'b0;
  logic [31:0] outData;
  logic [3:0]  outKeep;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] byteCnt, wordCnt;

  int          errors = 0;
  int          checks = 0;
  logic [35:0] expQ[$];
  logic [31:0] mdlWord = '0;
  int          mdlCnt = 0;
  int          mdlBytes = 0;
  int          mdlWords = 0;

  off_chip_rx_packer #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .in_data_i  (inData),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .flush_i    (flush),
    .out_data_o (outData),
    .out_keep_o (outKeep),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .byte_cnt_o (byteCnt),
    .word_cnt_o (wordCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelPush(input logic [31:0] data, input logic [3:0] keep);
    expQ.push_back({keep, data});
    mdlWords++;
    mdlWord = '0;
    mdlCnt  = 0;
  endtask

  // One cycle of stimulus, entered and left at posedge+1; the model mirrors
  // the packing rules for bytes accepted and flushes issued in the fill state.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, output bit xfer);
    inValid = v;
    inData  = d;
    flush   = f;
    @(negedge clk);
    xfer = v && inReady;
    if (xfer) begin
      mdlWord[8*mdlCnt +: 8] = d;
      mdlCnt++;
      mdlBytes++;
      if (mdlCnt == 4) modelPush(mdlWord, 4'hF);
    end
    if (f && mdlCnt != 0) modelPush(mdlWord, 4'((1 << mdlCnt) - 1));
    @(posedge clk);
    #1;
    inValid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d);
    bit x = 1'b0;
    for (int c = 0; c < 50 && !x; c++) applyStimulus(1'b1, d, 1'b0, x);
    if (!x) checkOutput("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    bit x;
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 8'h00, 1'b0, x);
  endtask

  task automatic waitDrain(input string tag);
    bit x;
    for (int c = 0; c < 100 && expQ.size() != 0; c++) applyStimulus(1'b0, 8'h00, 1'b0, x);
    checkOutput({tag, "_drain"}, 64'(expQ.size()), 64'(0));
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_byte_cnt"}, 64'(byteCnt), StatsEn ? 64'(16'(mdlBytes)) : 64'(0));
    checkOutput({tag, "_word_cnt"}, 64'(wordCnt), StatsEn ? 64'(16'(mdlWords)) : 64'(0));
  endtask

  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 64'({outKeep, outData}), 64'(0));
      end else begin
        logic [35:0] e;
        e = expQ.pop_front();
        checkOutput("out_data", 64'(outData), 64'(e[31:0]));
        checkOutput("out_keep", 64'(outKeep), 64'(e[35:32]));
      end
    end
  end

  initial begin
    bit x;
    int sent;

    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(inReady), 64'(0));
    checkOutput("rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("rst_out_data", 64'(outData), 64'(0));
    checkOutput("rst_out_keep", 64'(outKeep), 64'(0));
    checkCounters("rst");
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 64'(inReady), 64'(1));

    // Back-to-back full word; head must be visible right after the 4th edge.
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    sendByte(8'h44);
    checkOutput("word_latency", 64'(outValid), 64'(1));
    waitDrain("full_word");
    checkCounters("full_word");

    // Partial word via flush, then the next word starts at lane 0.
    sendByte(8'hAA);
    sendByte(8'hBB);
    applyStimulus(1'b0, 8'h00, 1'b1, x);
    for (int i = 1; i <= 4; i++) sendByte(8'(i));
    waitDrain("flush_partial");
    checkCounters("flush_partial");

    // Backpressure: the FIFO fills, lane 3 of the fifth word stalls.
    outReady = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && sent < 20; c++) begin
      applyStimulus(1'b1, 8'(8'h40 + sent), 1'b0, x);
      if (x) sent++;
    end
    checkOutput("stall_accepted", 64'(sent), 64'(19));
    checkOutput("stall_in_ready", 64'(inReady), 64'(0));
    outReady = 1'b1;
    while (sent < 20) begin
      sendByte(8'(8'h40 + sent));
      sent++;
    end
    waitDrain("stall");
    checkCounters("stall");

    // Flush against a full FIFO parks the partial word until one slot frees.
    outReady = 1'b0;
    for (int i = 0; i < 16; i++) sendByte(8'(8'h80 + i));
    sendByte(8'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, x);
    checkOutput("flush_wait_in_ready", 64'(inReady), 64'(0));
    idle(1);
    checkOutput("flush_wait_hold", 64'(inReady), 64'(0));
    outReady = 1'b1;
    idle(1);
    outReady = 1'b0;
    idle(2);
    checkOutput("flush_wait_exit", 64'(inReady), 64'(1));
    checkOutput("flush_wait_valid", 64'(outValid), 64'(1));
    outReady = 1'b1;
    waitDrain("flush_wait");
    checkCounters("flush_wait");

    // Flush together with the 4th byte yields one full word only.
    sendByte(8'hC1);
    sendByte(8'hC2);
    sendByte(8'hC3);
    applyStimulus(1'b1, 8'hC4, 1'b1, x);
    checkOutput("coinc_xfer", 64'(x), 64'(1));
    waitDrain("coinc");
    idle(3);
    checkOutput("coinc_no_extra", 64'(outValid), 64'(0));
    checkCounters("coinc");

    // Reset in the middle of a word with two words queued.
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) sendByte(8'(8'hD0 + i));
    checkOutput("pre_rst_valid", 64'(outValid), 64'(1));
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(inReady), 64'(0));
    expQ.delete();
    mdlWord  = '0;
    mdlCnt   = 0;
    mdlBytes = 0;
    mdlWords = 0;
    checkCounters("mid_rst");
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rerst_in_ready", 64'(inReady), 64'(1));
    sendByte(8'hE1);
    sendByte(8'hE2);
    sendByte(8'hE3);
    sendByte(8'hE4);
    outReady = 1'b1;
    waitDrain("after_rst");
    idle(2);
    checkOutput("after_rst_single", 64'(outValid), 64'(0));
    checkCounters("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
